c499_key_loader: RTL and testbench
==================================

# c499_key_loader

Serial key-provisioning stage that sits directly upstream of the locked c499 error-correction core. It shifts in the 10-bit unlock key: 4 MUX-select bits that drive `p1..p4` and 6 XOR-key bits that drive `X_1..X_6`. It checks the key against a trailing parity bit and, only on a match, drives the key onto the core's key inputs. Until a good key is committed, the key outputs are held at zero, so the core runs in its locked (wrong-key) configuration.

## Interface
- `MUX_W`, default 4: number of MUX key bits (`p1..p4`).
- `XOR_W`, default 6: number of XOR key bits (`X_1..X_6`).
- `clk` input 1: sole clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `key_start` input 1: one-cycle pulse that begins (or restarts) a key load.
- `key_sin` input 1: serial key data.
- `key_sin_valid` input 1: `key_sin` is consumed on this edge.
- `key_p` output MUX_W: applied MUX key, `key_p[i]` drives `p(i+1)`.
- `key_x` output XOR_W: applied XOR key, `key_x[i]` drives `X_(i+1)`.
- `key_ready` output 1: committed key is being driven.
- `key_err` output 1: last load failed its parity check.
- `busy` output 1: a load is in progress.

## Operation
- FSM states: IDLE, SHIFT, PAR, LOCKED, ERR.
- Shadow register: width MUX_W+XOR_W = 10.
- Bit counter: 4-bit, counts 0..9.
- Stream order is LSB-first. Bits 0..3 load `p[0..3]`, bits 4..9 load `x[0..5]`, and bit 10 is the parity bit.
- The parity bit must equal the XOR of the 10 key bits (even parity over all 11 bits).
- IDLE:
  - `key_start` → SHIFT; clear shadow and counter.
  - `key_sin_valid` alone is ignored.
- SHIFT:
  - Each `key_sin_valid` writes `key_sin` into `shadow[cnt]` and increments `cnt`.
  - The valid edge with `cnt`=9 → PAR.
  - Cycles with `key_sin_valid`=0 stall, with no timeout.
- PAR:
  - Next `key_sin_valid` compares `key_sin` with XOR(shadow).
  - Match → LOCKED: `key_p`/`key_x` load from the shadow on the same edge and `key_ready`=1.
  - Mismatch → ERR: `key_err`=1 and the key outputs stay 0.
- LOCKED: terminal until reset. `key_start` and `key_sin_valid` are ignored and the key outputs do not change.
- ERR: `key_start` → SHIFT, which clears `key_err` and the shadow.
- `key_start` in SHIFT or PAR restarts the load: shadow and counter clear, state becomes SHIFT.
- `key_start` and `key_sin_valid` asserted on the same edge: `key_start` wins and the data bit is discarded.
- Key outputs are never driven from a partial shadow; they change only on the PAR→LOCKED edge or on reset.
- `busy`=1 in SHIFT and PAR, otherwise 0.

## Timing
- Reset (asynchronous, immediate, independent of `clk`): state=IDLE; shadow=0, cnt=0; `key_p`=0, `key_x`=0, `key_ready`=0, `key_err`=0, `busy`=0.
- Reset asserted mid-load or while LOCKED discards everything; a full reload is required after release.
- All outputs are registered, with no combinational path from inputs to outputs.
- Minimum load latency: `key_start` at edge T0, then valid bits on edges T1..T11. `key_ready`/`key_err` and the key outputs are valid after edge T11.
- `busy` rises after T0 and falls after T11.
- Stall cycles add latency one-for-one.

## Test plan
- Good key: reset, `key_start`, then 11 back-to-back valid bits 0,1,1,0,1,0,1,1,0,1,0 (p=4'b0110, x=6'b101101, parity 0). Required after the 11th edge: `key_p`=4'b0110, `key_x`=6'b101101, `key_ready`=1, `key_err`=0, `busy`=0. Key outputs must be 0 on every earlier cycle.
- Bad parity: same 10 bits, then parity bit 1. Required: `key_err`=1, `key_ready`=0, key outputs 0. Then `key_start` followed by the correct 11-bit stream must reach LOCKED with `key_err` cleared.
- Stalls and restart: insert 3 idle cycles after bit 4, then pulse `key_start` after bit 7. Required: the counter restarts, and only the subsequent full 11-bit stream 1,0,0,0,0,0,0,0,0,0,1 yields `key_p`=4'b0001, `key_x`=0, `key_ready`=1.
- Same-edge priority: assert `key_start` with `key_sin_valid`=1 in IDLE and in SHIFT. Required: the data bit is discarded and the state is SHIFT with cnt=0.
- Lock persistence: after LOCKED, drive `key_start` plus 11 valid bits of all-ones. Required: outputs stay 4'b0110/6'b101101 and `busy`=0.
- Async reset: assert `rst` between clock edges while LOCKED and while in SHIFT at cnt=5. Required: all outputs are 0 immediately, without waiting for a clock edge, and state is IDLE after release.

Source files
------------

// File: rtl/c499_key_loader.sv
// Serial unlock-key loader for the locked c499 core: shifts in MUX/XOR key bits
// LSB-first, checks a trailing even-parity bit, and commits the key only on a match.
module c499_key_loader #(
  parameter int MUX_W = 4,
  parameter int XOR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sin,
  input  logic             key_sin_valid,
  output logic [MUX_W-1:0] key_p,
  output logic [XOR_W-1:0] key_x,
  output logic             key_ready,
  output logic             key_err,
  output logic             busy
);
  localparam int KEY_W = MUX_W + XOR_W;
  localparam int CNT_W = $clog2(KEY_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, PAR, LOCKED, ERR} state_t;

  state_t           state;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      key_p     <= '0;
      key_x     <= '0;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (key_start) begin
            state   <= SHIFT;
            shadow  <= '0;
            cnt     <= '0;
            key_err <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          // key_start outranks a same-edge data bit: restart and drop the bit
          if (key_start) begin
            shadow <= '0;
            cnt    <= '0;
          end else if (key_sin_valid) begin
            shadow[cnt] <= key_sin;
            if (cnt == CNT_LAST) begin
              state <= PAR;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (key_start) begin
            state  <= SHIFT;
            shadow <= '0;
            cnt    <= '0;
          end else if (key_sin_valid) begin
            busy <= 1'b0;
            if (key_sin == ^shadow) begin
              state     <= LOCKED;
              key_p     <= shadow[MUX_W-1:0];
              key_x     <= shadow[KEY_W-1:MUX_W];
              key_ready <= 1'b1;
            end else begin
              state   <= ERR;
              key_err <= 1'b1;
            end
          end
        end
        LOCKED: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader: hand-computed key streams, parity failure,
// stalls/restart, same-edge priority, lock persistence and async reset.
module tb_c499_key_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b0;
  logic       key_sin = 1'b0;
  logic       key_sin_valid = 1'b0;
  logic [3:0] key_p;
  logic [5:0] key_x;
  logic       key_ready, key_err, busy;

  int nvec = 0;
  int nerr = 0;

  // LSB-first streams: bit 10 is parity
  localparam logic [10:0] GOOD  = 11'b01011010110; // p=0110 x=101101 par 0
  localparam logic [10:0] BAD   = 11'b11011010110; // same key, parity 1
  localparam logic [10:0] ALT   = 11'b10000000001; // p=0001 x=0 par 1
  localparam logic [10:0] ONES  = 11'b11111111111;

  c499_key_loader #(.MUX_W(4), .XOR_W(6)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_sin(key_sin),
    .key_sin_valid(key_sin_valid), .key_p(key_p), .key_x(key_x),
    .key_ready(key_ready), .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic v, input logic d);
    key_start = 1'b1; key_sin_valid = v; key_sin = d;
    tick();
    key_start = 1'b0; key_sin_valid = 1'b0; key_sin = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    key_sin_valid = 1'b1; key_sin = b;
    tick();
    key_sin_valid = 1'b0; key_sin = 1'b0;
  endtask

  task automatic send_stream(input logic [10:0] s, input logic chk_mid);
    for (int i = 0; i < 11; i++) begin
      send_bit(s[i]);
      if (chk_mid && i < 10) begin
        chk("key_zero_mid", 16'({key_p, key_x}), 16'h0);
        chk("busy_mid", 16'(busy), 16'h1);
      end
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] p, input logic [5:0] x,
                          input logic rdy, input logic err, input logic bsy);
    chk({tag, "_p"}, 16'(key_p), 16'(p));
    chk({tag, "_x"}, 16'(key_x), 16'(x));
    chk({tag, "_ready"}, 16'(key_ready), 16'(rdy));
    chk({tag, "_err"}, 16'(key_err), 16'(err));
    chk({tag, "_busy"}, 16'(busy), 16'(bsy));
  endtask

  // Assert rst between edges and check outputs before any clock edge arrives
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_outs(tag, 4'h0, 6'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #1 chk_outs("reset", 4'h0, 6'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // good key, then lock persistence, then async reset while LOCKED
    pulse_start(1'b0, 1'b0);
    chk("busy_after_start", 16'(busy), 16'h1);
    send_stream(GOOD, 1'b1);
    chk_outs("good", 4'b0110, 6'b101101, 1'b1, 1'b0, 1'b0);
    pulse_start(1'b0, 1'b0);
    send_stream(ONES, 1'b0);
    chk_outs("persist", 4'b0110, 6'b101101, 1'b1, 1'b0, 1'b0);
    async_reset("rst_locked");
    chk_outs("idle_after_rst", 4'h0, 6'h0, 1'b0, 1'b0, 1'b0);

    // valid bits without start are ignored in IDLE; then bad parity and recovery
    send_bit(1'b1);
    send_bit(1'b1);
    chk("idle_ignores_valid", 16'(busy), 16'h0);
    pulse_start(1'b0, 1'b0);
    send_stream(BAD, 1'b1);
    chk_outs("bad", 4'h0, 6'h0, 1'b0, 1'b1, 1'b0);
    pulse_start(1'b0, 1'b0);
    chk("err_cleared", 16'(key_err), 16'h0);
    chk("busy_reload", 16'(busy), 16'h1);
    send_stream(GOOD, 1'b1);
    chk_outs("recover", 4'b0110, 6'b101101, 1'b1, 1'b0, 1'b0);

    // stalls after bit 4, restart after bit 7
    async_reset("rst_locked2");
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_busy", 16'(busy), 16'h1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("stall_key_zero", 16'({key_p, key_x}), 16'h0);
    pulse_start(1'b0, 1'b0);
    send_stream(ALT, 1'b1);
    chk_outs("restart", 4'b0001, 6'h0, 1'b1, 1'b0, 1'b0);

    // same-edge start+valid in IDLE discards the bit
    async_reset("rst_locked3");
    pulse_start(1'b1, 1'b1);
    chk("same_edge_idle_busy", 16'(busy), 16'h1);
    send_stream(GOOD, 1'b0);
    chk_outs("same_edge_idle", 4'b0110, 6'b101101, 1'b1, 1'b0, 1'b0);

    // same-edge start+valid in SHIFT restarts at cnt 0 and discards the bit
    async_reset("rst_locked4");
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    pulse_start(1'b1, 1'b1);
    send_stream(GOOD, 1'b0);
    chk_outs("same_edge_shift", 4'b0110, 6'b101101, 1'b1, 1'b0, 1'b0);

    // async reset mid-SHIFT at cnt 5, then a full reload is required
    async_reset("rst_locked5");
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    async_reset("rst_shift");
    for (int i = 0; i < 6; i++) send_bit(GOOD[i]);
    chk_outs("no_resume", 4'h0, 6'h0, 1'b0, 1'b0, 1'b0);
    pulse_start(1'b0, 1'b0);
    send_stream(ALT, 1'b1);
    chk_outs("reload", 4'b0001, 6'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
